// File: rtl/fpga_rom_loader.sv
// Purpose: streams host words into ROM BRAM port B at auto-incrementing word addresses,
//          keeps a 32-bit additive checksum and holds Caliptra in reset until a clean load.
// Latency: handshake in cycle N -> BRAM write strobe in N+1 -> done in N+2
//          (verify build: done n+2 cycles after the last write strobe).
// Backpressure: s_ready is high only while loading and drops right after the last accepted word.
//
// Optional feature macro: FPGA_ROM_LOADER_VERIFY_EN (read back the loaded image and compare sums).
//
// Ports:
//   axi_bram_clk / axi_bram_rst : sole clock, synchronous active-high reset
//   start, word_count           : load request and length (sampled only in IDLE/DONE)
//   s_valid, s_data, s_ready    : host word stream
//   axi_bram_en/we/addr/wrdata  : registered BRAM port B controls
//   axi_bram_rddata             : BRAM read data, one cycle after a read
//   busy, done, error, checksum : load status
//   cptra_rst_hold              : 1 keeps Caliptra in reset
module fpga_rom_loader #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) (
    input  logic              axi_bram_clk,
    input  logic              axi_bram_rst,
    input  logic              start,
    input  logic [ADDR_W:0]   word_count,
    input  logic              s_valid,
    input  logic [31:0]       s_data,
    output logic              s_ready,
    output logic              axi_bram_en,
    output logic [3:0]        axi_bram_we,
    output logic [ADDR_W-1:0] axi_bram_addr,
    output logic [31:0]       axi_bram_wrdata,
    input  logic [31:0]       axi_bram_rddata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       checksum,
    output logic              cptra_rst_hold
);

    generate
        if (DATA_W != 32) begin : g_data_w_check
            $error("fpga_rom_loader: DATA_W must be 32");
        end
    endgenerate

    localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE       = {{ADDR_W{1'b0}}, 1'b1};

`ifdef FPGA_ROM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_VERIFY, ST_DRAIN, ST_DONE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_DONE} state_t;
`endif

    state_t          state;
    logic [ADDR_W:0] cnt;   // words requested for the current load
    logic [ADDR_W:0] idx;   // words accepted so far

`ifdef FPGA_ROM_LOADER_VERIFY_EN
    logic [ADDR_W:0] rd_idx;
    logic [31:0]     rb_sum;
    logic            rd_pend;  // a read was on the bus last cycle, rddata is valid now
    logic [31:0]     rb_final;
    assign rb_final = rb_sum + (rd_pend ? axi_bram_rddata : 32'h0);
`else
    logic unused_rddata;
    assign unused_rddata = ^axi_bram_rddata;
`endif

    always_ff @(posedge axi_bram_clk) begin
        if (axi_bram_rst) begin
            state           <= ST_IDLE;
            s_ready         <= 1'b0;
            axi_bram_en     <= 1'b0;
            axi_bram_we     <= 4'h0;
            axi_bram_addr   <= '0;
            axi_bram_wrdata <= 32'h0;
            busy            <= 1'b0;
            done            <= 1'b0;
            error           <= 1'b0;
            checksum        <= 32'h0;
            cptra_rst_hold  <= 1'b1;
            cnt             <= '0;
            idx             <= '0;
`ifdef FPGA_ROM_LOADER_VERIFY_EN
            rd_idx          <= '0;
            rb_sum          <= 32'h0;
            rd_pend         <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    axi_bram_en <= 1'b0;
                    axi_bram_we <= 4'h0;
                    if (start) begin
                        if (word_count == '0) begin
                            state          <= ST_DONE;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            error          <= 1'b0;
                            checksum       <= 32'h0;
                            cptra_rst_hold <= 1'b0;
                        end else if (word_count > MAX_WORDS) begin
                            // Rejected before any BRAM access; Caliptra stays in reset.
                            state          <= ST_DONE;
                            busy           <= 1'b0;
                            done           <= 1'b1;
                            error          <= 1'b1;
                            checksum       <= 32'h0;
                            cptra_rst_hold <= 1'b1;
                        end else begin
                            state          <= ST_WRITE;
                            busy           <= 1'b1;
                            done           <= 1'b0;
                            error          <= 1'b0;
                            checksum       <= 32'h0;
                            cptra_rst_hold <= 1'b1;
                            cnt            <= word_count;
                            idx            <= '0;
                            s_ready        <= 1'b1;
                        end
                    end
                end

                ST_WRITE: begin
                    if (s_valid && s_ready) begin
                        axi_bram_en     <= 1'b1;
                        axi_bram_we     <= 4'hF;
                        axi_bram_addr   <= idx[ADDR_W-1:0];
                        axi_bram_wrdata <= s_data;
                        checksum        <= checksum + s_data;
                        idx             <= idx + ONE;
                        if (idx + ONE == cnt) begin
                            s_ready <= 1'b0;
                        end
                    end else begin
                        axi_bram_en <= 1'b0;
                        axi_bram_we <= 4'h0;
                    end
                    // s_ready is low inside WRITE only while the final write strobe is on the bus.
                    if (!s_ready) begin
`ifdef FPGA_ROM_LOADER_VERIFY_EN
                        state         <= ST_VERIFY;
                        axi_bram_en   <= 1'b1;
                        axi_bram_we   <= 4'h0;
                        axi_bram_addr <= '0;
                        rd_idx        <= ONE;
                        rb_sum        <= 32'h0;
                        rd_pend       <= 1'b0;
`else
                        state          <= ST_DONE;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                        error          <= 1'b0;
                        cptra_rst_hold <= 1'b0;
`endif
                    end
                end

`ifdef FPGA_ROM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    rd_pend <= axi_bram_en;
                    if (rd_pend) begin
                        rb_sum <= rb_sum + axi_bram_rddata;
                    end
                    if (rd_idx == cnt) begin
                        axi_bram_en <= 1'b0;
                        state       <= ST_DRAIN;
                    end else begin
                        axi_bram_en   <= 1'b1;
                        axi_bram_addr <= rd_idx[ADDR_W-1:0];
                        rd_idx        <= rd_idx + ONE;
                    end
                end

                ST_DRAIN: begin
                    // The last read's data arrives this cycle; fold it in before comparing.
                    rd_pend        <= 1'b0;
                    state          <= ST_DONE;
                    busy           <= 1'b0;
                    done           <= 1'b1;
                    error          <= (rb_final != checksum);
                    cptra_rst_hold <= (rb_final != checksum);
                end
`endif

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
